// File: rtl/axis_uart_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream UART TX path.
// Optional stall watchdog enabled by defining ARB_STALL_TIMEOUT_EN.
module axis_uart_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ*DATA_BITS-1:0]   s_axis_data,
   input  logic [NUM_REQ-1:0]             s_axis_valid,
   input  logic [NUM_REQ-1:0]             s_axis_last,
   output logic [NUM_REQ-1:0]             s_axis_ready,
   output logic [DATA_BITS-1:0]           m_axis_data,
   output logic                           m_axis_valid,
   output logic                           m_axis_last,
   input  logic                           m_axis_ready,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           busy,
   output logic                           timeout_err
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("axis_uart_arbiter: parameter out of range");
   end

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic                 busy_q, busy_d;
   logic [IDX_W-1:0]     owner_s;
   logic [IDX_W:0]       pick_s;
   logic                 hs_s;

   // Returns {found, index} of the first request after 'last', wrapping around.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   last);
      logic [IDX_W:0] res;
      int             c;
      res = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         c   = (int'(last) + k) % NUM_REQ;
         res = req[c[IDX_W-1:0]] ? {1'b1, c[IDX_W-1:0]} : res;
      end
      return res;
   endfunction

   function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
      logic [IDX_W-1:0] res;
      res = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         res = oh[i] ? IDX_W'(i) : res;
      end
      return res;
   endfunction

   assign owner_s = onehot_idx(grant_q);
   assign pick_s  = rr_pick(s_axis_valid, last_q);
   assign hs_s    = m_axis_valid & m_axis_ready;

   // Zero-latency passthrough of the owning source while a packet is owned.
   always_comb begin
      m_axis_data  = '0;
      m_axis_valid = 1'b0;
      m_axis_last  = 1'b0;
      s_axis_ready = '0;
      if (state_q == ST_ACTIVE) begin
         m_axis_data  = s_axis_data[int'(owner_s)*DATA_BITS +: DATA_BITS];
         m_axis_valid = s_axis_valid[owner_s];
         m_axis_last  = s_axis_last[owner_s];
         s_axis_ready = grant_q & {NUM_REQ{m_axis_ready}};
      end else begin
         s_axis_ready = '0;
      end
   end

`ifdef ARB_STALL_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SW-1:0] stall_q, stall_d;
   logic          terr_q, terr_d;
`endif

   // Next-state: arbitrate in IDLE, hold the grant until the last beat handshakes.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
`ifdef ARB_STALL_TIMEOUT_EN
      stall_d = stall_q;
      terr_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef ARB_STALL_TIMEOUT_EN
            stall_d = '0;
`endif
            if (pick_s[IDX_W]) begin
               state_d = ST_ACTIVE;
               grant_d = NUM_REQ'(1) << pick_s[IDX_W-1:0];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (hs_s && m_axis_last) begin
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = owner_s;
`ifdef ARB_STALL_TIMEOUT_EN
            end else if (s_axis_valid[owner_s]) begin
               stall_d = '0;
            end else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
               // Owner stalled too long: release without fabricating a beat.
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = owner_s;
               stall_d = '0;
               terr_d  = 1'b1;
            end else begin
               stall_d = stall_q + SW'(1);
`else
            end else begin
               state_d = ST_ACTIVE;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
      busy_d = (state_d == ST_ACTIVE);
   end

   // State and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         busy_q  <= 1'b0;
`ifdef ARB_STALL_TIMEOUT_EN
         stall_q <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
`ifdef ARB_STALL_TIMEOUT_EN
         stall_q <= stall_d;
         terr_q  <= terr_d;
`endif
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
`ifdef ARB_STALL_TIMEOUT_EN
   assign timeout_err = terr_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_uart_arbiter.sv
// Directed self-checking bench for axis_uart_arbiter (4 sources, 8-bit beats).
module tb_axis_uart_arbiter;
`ifdef ARB_STALL_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] s_axis_data;
   logic [3:0]  s_axis_valid;
   logic [3:0]  s_axis_last;
   logic [3:0]  s_axis_ready;
   logic [7:0]  m_axis_data;
   logic        m_axis_valid;
   logic        m_axis_last;
   logic        m_axis_ready;
   logic [3:0]  grant;
   logic        busy;
   logic        timeout_err;

   int checks;
   int failures;

   // Source model: each source walks sd[i][0..tlen-1], packets of plen beats.
   logic [7:0] sd [4][4];
   int         plen [4];
   int         tlen [4];
   int         ptr  [4];
   logic [3:0] hs_cap;

   axis_uart_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
      .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
      .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
      .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
      .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_srcs();
      for (int i = 0; i < 4; i++) begin
         if (ptr[i] < tlen[i]) begin
            s_axis_valid[i]       = 1'b1;
            s_axis_data[i*8 +: 8] = sd[i][ptr[i]];
            s_axis_last[i]        = (((ptr[i] + 1) % plen[i]) == 0);
         end else begin
            s_axis_valid[i]       = 1'b0;
            s_axis_data[i*8 +: 8] = 8'h00;
            s_axis_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic clear_srcs();
      for (int i = 0; i < 4; i++) begin
         plen[i] = 1;
         tlen[i] = 0;
         ptr[i]  = 0;
      end
   endtask

   task automatic cycle();
      hs_cap = s_axis_valid & s_axis_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (hs_cap[i]) ptr[i] = ptr[i] + 1;
      end
      drive_srcs();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      m_axis_ready = 1'b0;
      clear_srcs();
      drive_srcs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_srcs();
      for (int i = 0; i < 4; i++) begin
         sd[i][0] = 8'hEE;
         tlen[i]  = 1;
      end
      drive_srcs();
      m_axis_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (grant !== 4'h0) begin failures++; $display("FAIL reset_grant: got %h want 0", grant); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (m_axis_valid !== 1'b0) begin failures++; $display("FAIL reset_mvalid: got %b want 0", m_axis_valid); end
      checks++; if (s_axis_ready !== 4'h0) begin failures++; $display("FAIL reset_sready: got %h want 0", s_axis_ready); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
   endtask

   task automatic test_packets();
      logic [3:0] eg [9];
      logic       ev [9];
      logic [7:0] ed [9];
      logic       el [9];
      apply_reset();
      eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
      ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ed = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'h00, 8'hC0, 8'hC1, 8'hC2, 8'h00};
      el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      sd[0][0] = 8'hA0; sd[0][1] = 8'hA1; sd[0][2] = 8'hA2; plen[0] = 3; tlen[0] = 3;
      sd[2][0] = 8'hC0; sd[2][1] = 8'hC1; sd[2][2] = 8'hC2; plen[2] = 3; tlen[2] = 3;
      m_axis_ready = 1'b1;
      drive_srcs();
      for (int c = 0; c < 9; c++) begin
         #1;
         checks++; if (grant !== eg[c]) begin failures++; $display("FAIL pkt_grant c%0d: got %h want %h", c, grant, eg[c]); end
         checks++; if (busy !== (eg[c] != 4'h0)) begin failures++; $display("FAIL pkt_busy c%0d: got %b", c, busy); end
         checks++; if (m_axis_valid !== ev[c]) begin failures++; $display("FAIL pkt_mvalid c%0d: got %b want %b", c, m_axis_valid, ev[c]); end
         checks++; if (s_axis_ready !== eg[c]) begin failures++; $display("FAIL pkt_sready c%0d: got %h want %h", c, s_axis_ready, eg[c]); end
         if (ev[c]) begin
            checks++; if (m_axis_data !== ed[c]) begin failures++; $display("FAIL pkt_data c%0d: got %h want %h", c, m_axis_data, ed[c]); end
            checks++; if (m_axis_last !== el[c]) begin failures++; $display("FAIL pkt_last c%0d: got %b want %b", c, m_axis_last, el[c]); end
         end
         cycle();
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] eg;
      int         src;
      int         beat;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         sd[i][0] = 8'(16 * (i + 1));
         sd[i][1] = 8'(16 * (i + 1) + 1);
         plen[i]  = 1;
         tlen[i]  = 2;
      end
      m_axis_ready = 1'b1;
      drive_srcs();
      for (int c = 0; c < 16; c++) begin
         #1;
         src  = ((c - 1) / 2) % 4;
         beat = (c - 1) / 8;
         eg   = (c % 2 == 1) ? 4'(1 << src) : 4'h0;
         checks++; if (grant !== eg) begin failures++; $display("FAIL rr_grant c%0d: got %h want %h", c, grant, eg); end
         checks++; if (m_axis_valid !== (c % 2 == 1)) begin failures++; $display("FAIL rr_mvalid c%0d: got %b", c, m_axis_valid); end
         if (c % 2 == 1) begin
            checks++; if (m_axis_data !== 8'(16 * (src + 1) + beat)) begin failures++; $display("FAIL rr_data c%0d: got %h want %h", c, m_axis_data, 8'(16 * (src + 1) + beat)); end
            checks++; if (m_axis_last !== 1'b1) begin failures++; $display("FAIL rr_last c%0d: got %b want 1", c, m_axis_last); end
         end
         cycle();
      end
   endtask

   task automatic test_backpressure();
      logic       rdy [8];
      logic [3:0] eg  [8];
      logic       ev  [8];
      logic [7:0] ed  [8];
      logic       el  [8];
      logic [3:0] er;
      apply_reset();
      rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      eg  = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h0};
      ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      ed  = '{8'h00, 8'h55, 8'h66, 8'h66, 8'h66, 8'h00, 8'h33, 8'h00};
      el  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      sd[1][0] = 8'h55; sd[1][1] = 8'h66; plen[1] = 2; tlen[1] = 2;
      sd[3][0] = 8'h33; plen[3] = 1; tlen[3] = 1;
      drive_srcs();
      for (int c = 0; c < 8; c++) begin
         m_axis_ready = rdy[c];
         #1;
         er = eg[c] & {4{rdy[c]}};
         checks++; if (grant !== eg[c]) begin failures++; $display("FAIL bp_grant c%0d: got %h want %h", c, grant, eg[c]); end
         checks++; if (m_axis_valid !== ev[c]) begin failures++; $display("FAIL bp_mvalid c%0d: got %b want %b", c, m_axis_valid, ev[c]); end
         checks++; if (s_axis_ready !== er) begin failures++; $display("FAIL bp_sready c%0d: got %h want %h", c, s_axis_ready, er); end
         if (ev[c]) begin
            checks++; if (m_axis_data !== ed[c]) begin failures++; $display("FAIL bp_data c%0d: got %h want %h", c, m_axis_data, ed[c]); end
            checks++; if (m_axis_last !== el[c]) begin failures++; $display("FAIL bp_last c%0d: got %b want %b", c, m_axis_last, el[c]); end
         end
         cycle();
      end
      checks++; if (ptr[1] !== 2 || ptr[3] !== 1) begin failures++; $display("FAIL bp_beats: got %0d/%0d want 2/1", ptr[1], ptr[3]); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      sd[2][0] = 8'hC0; sd[2][1] = 8'hC1; sd[2][2] = 8'hC2; plen[2] = 3; tlen[2] = 3;
      m_axis_ready = 1'b1;
      drive_srcs();
      cycle();
      cycle();
      #1;
      checks++; if (grant !== 4'h4 || m_axis_data !== 8'hC1) begin failures++; $display("FAIL rm_pre: got %h/%h want 4/c1", grant, m_axis_data); end
      rst_n = 1'b0;
      #1;
      checks++; if (grant !== 4'h0) begin failures++; $display("FAIL rm_grant: got %h want 0", grant); end
      checks++; if (m_axis_valid !== 1'b0) begin failures++; $display("FAIL rm_mvalid: got %b want 0", m_axis_valid); end
      checks++; if (busy !== 1'b0 || s_axis_ready !== 4'h0) begin failures++; $display("FAIL rm_busy: got %b/%h want 0/0", busy, s_axis_ready); end
      clear_srcs();
      sd[1][0] = 8'h11; tlen[1] = 1;
      sd[2][0] = 8'hC0; tlen[2] = 1;
      sd[3][0] = 8'h33; tlen[3] = 1;
      drive_srcs();
      #1;
      rst_n = 1'b1;
      cycle();
      #1;
      checks++; if (grant !== 4'h2) begin failures++; $display("FAIL rm_regrant: got %h want 2", grant); end
      checks++; if (m_axis_data !== 8'h11 || m_axis_valid !== 1'b1) begin failures++; $display("FAIL rm_data: got %h/%b want 11/1", m_axis_data, m_axis_valid); end
   endtask

   task automatic test_stall();
`ifdef ARB_STALL_TIMEOUT_EN
      logic [3:0] eg [8];
      logic       et [8];
      logic       ev [8];
`endif
      apply_reset();
      sd[0][0] = 8'h77; plen[0] = 2; tlen[0] = 1;
      sd[1][0] = 8'h99; plen[1] = 1; tlen[1] = 1;
      m_axis_ready = 1'b1;
      drive_srcs();
`ifdef ARB_STALL_TIMEOUT_EN
      eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2};
      et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++; if (grant !== eg[c]) begin failures++; $display("FAIL to_grant c%0d: got %h want %h", c, grant, eg[c]); end
         checks++; if (timeout_err !== et[c]) begin failures++; $display("FAIL to_terr c%0d: got %b want %b", c, timeout_err, et[c]); end
         checks++; if (busy !== (eg[c] != 4'h0)) begin failures++; $display("FAIL to_busy c%0d: got %b", c, busy); end
         checks++; if (m_axis_valid !== ev[c] || (!ev[c] && m_axis_last !== 1'b0)) begin failures++; $display("FAIL to_mvalid c%0d: got %b/%b want %b", c, m_axis_valid, m_axis_last, ev[c]); end
         cycle();
      end
`else
      for (int c = 0; c < 100; c++) begin
         #1;
         if (c > 0) begin
            checks++; if (grant !== 4'h1 || busy !== 1'b1) begin failures++; $display("FAIL hold_grant c%0d: got %h/%b want 1/1", c, grant, busy); end
         end
         checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL hold_terr c%0d: got %b want 0", c, timeout_err); end
         if (c > 1) begin
            checks++; if (m_axis_valid !== 1'b0 || s_axis_ready[1] !== 1'b0) begin failures++; $display("FAIL hold_mvalid c%0d: got %b/%b want 0/0", c, m_axis_valid, s_axis_ready[1]); end
         end
         cycle();
      end
`endif
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      m_axis_ready = 1'b0;
      s_axis_data  = 32'h0;
      s_axis_valid = 4'h0;
      s_axis_last  = 4'h0;
      hs_cap       = 4'h0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) sd[i][j] = 8'h00;
      end
      clear_srcs();
      test_reset();
      test_packets();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
